// File: rtl/instr_burst_reader.sv
// Instruction burst reader: turns one cache burst request into pipelined word reads.
// Latency: first mem_req the cycle after the request edge; each response reaches rd_* one cycle later.
// Backpressure: mem_gnt stalls issue (address held); up to MAX_OUT reads in flight; rd_valid has none.
module instr_burst_reader #(
  parameter int DWIDTH  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [DWIDTH-1:0] rd_addr,
  input  logic [11:0]       rd_len,
  output logic              rd_busy,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_eof,
  output logic              mem_req,
  output logic [DWIDTH-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [DWIDTH-1:0] base;
  logic [11:0]       len;
  logic [11:0]       issued;
  logic [11:0]       received;

  logic [11:0] in_flight;
  logic        slot_free;
  logic        grant;
  logic        resp;
  logic        last_resp;

  // Request gating uses only registered counts, so a response arriving this
  // cycle frees its slot one cycle later.
  always_comb begin
    in_flight = issued - received;
    slot_free = in_flight < 12'(MAX_OUT);
    rd_busy   = (state != ST_IDLE);
    mem_req   = (state == ST_ISSUE) && slot_free;
    mem_addr  = base + DWIDTH'({issued, 2'b00});
    grant     = mem_req && mem_gnt;
    resp      = rd_busy && mem_rvalid;
    last_resp = resp && ((received + 12'd1) == len);
  end

  // Burst control: latch request, count grants and responses, sequence states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      base     <= '0;
      len      <= '0;
      issued   <= '0;
      received <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_req && (rd_len != 12'd0)) begin
            base     <= rd_addr & ~DWIDTH'(3);
            len      <= rd_len;
            issued   <= '0;
            received <= '0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (grant) begin
            issued <= issued + 12'd1;
            if ((issued + 12'd1) == len) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // waiting for the remaining responses only
        end
        default: state <= ST_IDLE;
      endcase

      // Responses are only counted while a burst is live; stray ones in IDLE are dropped.
      if (resp) begin
        received <= received + 12'd1;
        if (last_resp) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  // Output stage: forward each accepted response one cycle later, flag the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_eof   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= resp;
      rd_eof   <= last_resp;
      if (resp) begin
        rd_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_instr_burst_reader.sv
// Bench for instr_burst_reader: directed bursts against a burst-level reference model.
// Memory responder returns data derived from the granted address after a programmable latency.
// Checks every cycle at the falling edge plus literal expectations per scenario.
module tb_instr_burst_reader;

  localparam int DW = 32;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0;
  logic [DW-1:0] rd_addr = '0;
  logic [11:0]   rd_len = '0;
  logic          rd_busy;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_eof;
  logic          mem_req;
  logic [DW-1:0] mem_addr;
  logic          mem_gnt = 1'b1;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  instr_burst_reader #(.DWIDTH(DW), .MAX_OUT(MO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_len    (rd_len),
    .rd_busy   (rd_busy),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_eof    (rd_eof),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // cycle counter and memory responder state
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          lat = 1;
  bit          gnt_tog = 1'b0;
  int          stray = 0;
  logic [31:0] pq_a[$];
  int          pq_t[$];

  // observation records
  int          n_beats = 0;
  int          eof_idx = 0;
  int          n_resp = 0;
  int          first_rv_grants = -1;
  logic [31:0] beat_dat[$];
  logic [31:0] gaddr[$];
  bit          cmp_en = 1'b0;

  // reference model: burst-level view
  bit          m_busy = 1'b0;
  bit          m_issuing = 1'b0;
  logic [31:0] m_base = '0;
  int          m_len = 0;
  int          m_iss = 0;
  int          m_rcv = 0;
  bit          e_valid = 1'b0;
  bit          e_eof = 1'b0;
  logic [31:0] e_data = '0;

  // Memory: grant pattern, then in-order responses once their latency has elapsed.
  always @(posedge clk) begin
    #2;
    mem_rvalid = 1'b0;
    mem_gnt = gnt_tog ? ~mem_gnt : 1'b1;
    if (stray > 0) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'hDEAD_0000 + 32'(stray);
      stray--;
    end else if (pq_a.size() > 0 && pq_t[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata = dat(pq_a[0]);
      void'(pq_a.pop_front());
      void'(pq_t.pop_front());
    end
  end

  // Compare, record, then advance the model by the edge that follows.
  always @(negedge clk) begin
    bit          exp_req;
    logic [31:0] exp_addr;
    exp_req  = m_busy && m_issuing && ((m_iss - m_rcv) < MO);
    exp_addr = m_base + 32'(4 * m_iss);
    if (cmp_en) begin
      chk("rd_busy", rd_busy, m_busy);
      chk("mem_req", mem_req, exp_req);
      chk("mem_addr", mem_addr, exp_addr);
      chk("rd_valid", rd_valid, e_valid);
      chk("rd_eof", rd_eof, e_eof);
      chk("rd_data", rd_data, e_data);
    end
    if (rd_valid) begin
      n_beats++;
      beat_dat.push_back(rd_data);
      if (rd_eof) eof_idx = n_beats;
    end
    if (!rst && mem_rvalid && m_busy) begin
      n_resp++;
      if (first_rv_grants < 0) first_rv_grants = gaddr.size();
    end
    if (!rst && mem_req && mem_gnt) begin
      pq_a.push_back(mem_addr);
      pq_t.push_back(cyc + lat);
      gaddr.push_back(mem_addr);
    end
    if (rst) begin
      m_busy = 1'b0; m_issuing = 1'b0; m_base = '0;
      m_len = 0; m_iss = 0; m_rcv = 0;
      e_valid = 1'b0; e_eof = 1'b0; e_data = '0;
    end else begin
      e_valid = 1'b0;
      e_eof = 1'b0;
      if (m_busy) begin
        if (mem_rvalid) begin
          e_valid = 1'b1;
          e_data = mem_rdata;
          m_rcv++;
          if (m_rcv == m_len) begin
            e_eof = 1'b1;
            m_busy = 1'b0;
          end
        end
        if (exp_req && mem_gnt) begin
          m_iss++;
          if (m_iss == m_len) m_issuing = 1'b0;
        end
      end else if (rd_req && rd_len != 12'd0) begin
        m_busy = 1'b1;
        m_issuing = 1'b1;
        m_base = rd_addr & ~32'd3;
        m_len = int'(rd_len);
        m_iss = 0;
        m_rcv = 0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [11:0] l);
    rd_addr = a;
    rd_len = l;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic clear_stats();
    n_beats = 0;
    eof_idx = 0;
    n_resp = 0;
    first_rv_grants = -1;
    beat_dat.delete();
    gaddr.delete();
  endtask

  task automatic wait_eof(input string name, input int budget);
    int t = 0;
    while (eof_idx == 0 && t < budget) begin
      tick();
      t++;
    end
    chk(name, (eof_idx != 0), 1);
  endtask

  task automatic check_addrs(input string name, input logic [31:0] ea[$]);
    chk(name, gaddr.size(), ea.size());
    foreach (ea[i]) if (i < gaddr.size()) chk(name, gaddr[i], ea[i]);
  endtask

  task automatic check_beats(input string name, input logic [31:0] base, input int n);
    chk(name, n_beats, n);
    for (int i = 0; i < n; i++)
      if (i < beat_dat.size()) chk(name, beat_dat[i], dat(base + 32'(4 * i)));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_busy"}, rd_busy, 0);
    chk({name, "_valid"}, rd_valid, 0);
    chk({name, "_eof"}, rd_eof, 0);
    chk({name, "_req"}, mem_req, 0);
    chk({name, "_data"}, rd_data, 0);
    chk({name, "_addr"}, mem_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats_at_rst;
    int t;
    tick(2);
    check_reset_outputs("reset");
    cmp_en = 1'b1;
    rst = 1'b0;
    tick();

    // basic 3-word burst, misaligned start address
    lat = 1;
    clear_stats();
    start(32'h1003, 12'd3);
    wait_eof("t1_done", 50);
    tick(2);
    check_addrs("t1_addr", '{32'h1000, 32'h1004, 32'h1008});
    check_beats("t1_beats", 32'h1000, 3);
    chk("t1_eof_idx", eof_idx, 3);
    chk("t1_idle", rd_busy, 0);

    // slow memory: outstanding limit caps issue at four
    lat = 10;
    clear_stats();
    start(32'h4000, 12'd8);
    wait_eof("t2_done", 200);
    tick(2);
    chk("t2_grants_before_rsp", first_rv_grants, 4);
    check_beats("t2_beats", 32'h4000, 8);
    chk("t2_eof_idx", eof_idx, 8);

    // grant toggling every cycle
    lat = 1;
    gnt_tog = 1'b1;
    clear_stats();
    start(32'h5000, 12'd2);
    wait_eof("t3_done", 50);
    tick(2);
    gnt_tog = 1'b0;
    check_addrs("t3_addr", '{32'h5000, 32'h5004});
    chk("t3_eof_idx", eof_idx, 2);

    // zero-length request and request during a busy burst are both ignored
    clear_stats();
    start(32'h6000, 12'd0);
    tick(3);
    chk("t4_len0_busy", rd_busy, 0);
    chk("t4_len0_grants", gaddr.size(), 0);
    lat = 10;
    start(32'h7000, 12'd2);
    tick(2);
    start(32'h8000, 12'd5);
    wait_eof("t4_done", 100);
    tick(12);
    check_addrs("t4_addr", '{32'h7000, 32'h7004});
    check_beats("t4_beats", 32'h7000, 2);
    chk("t4_idle", rd_busy, 0);

    // reset mid-burst, then stray responses
    lat = 3;
    clear_stats();
    start(32'h9000, 12'd5);
    t = 0;
    while (n_resp < 2 && t < 50) begin
      tick();
      t++;
    end
    chk("t5_two_resp", (n_resp >= 2), 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("t5_rst");
    rst = 1'b0;
    beats_at_rst = n_beats;
    chk("t5_partial", (beats_at_rst < 5), 1);
    stray = 3;
    tick(15);
    chk("t5_no_stray_beats", n_beats, beats_at_rst);
    chk("t5_no_eof", eof_idx, 0);
    chk("t5_idle", rd_busy, 0);

    // address wrap at the top of the address space
    lat = 1;
    clear_stats();
    start(32'hFFFF_FFFC, 12'd2);
    wait_eof("t6_done", 50);
    tick(2);
    check_addrs("t6_addr", '{32'hFFFF_FFFC, 32'h0000_0000});
    chk("t6_eof_idx", eof_idx, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_burst_reader.md
INSTR_BURST_READER -- requirements
Module: instr_burst_reader

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data and address width in bits.
REQ-002 SHALL have parameter MAX_OUT, default 4, maximum outstanding memory reads (power of 2, 1..16).
REQ-003 SHALL have port clk, input, 1, the only clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-005 SHALL have port rd_req, input, 1, burst request from the instruction cache, sampled only in IDLE.
REQ-006 SHALL have port rd_addr, input, DWIDTH, burst start byte address.
REQ-007 SHALL have port rd_len, input, 12, burst length in words.
REQ-008 SHALL have port rd_busy, output, 1, high while a burst is in progress.
REQ-009 SHALL have port rd_data, output, DWIDTH, returned instruction word.
REQ-010 SHALL have port rd_valid, output, 1, rd_data valid this cycle.
REQ-011 SHALL have port rd_eof, output, 1, marks the last word of a burst, qualified by rd_valid.
REQ-012 SHALL have port mem_req, output, 1, memory read request.
REQ-013 SHALL have port mem_addr, output, DWIDTH, memory read byte address.
REQ-014 SHALL have port mem_gnt, input, 1, memory accepts the request when mem_req and mem_gnt are both high.
REQ-015 SHALL have port mem_rvalid, input, 1, in-order read response valid.
REQ-016 SHALL have port mem_rdata, input, DWIDTH, read response data.

Function
REQ-017 SHALL implement states IDLE, ISSUE and DRAIN.
REQ-018 In IDLE, rd_req=1 with rd_len!=0 SHALL, at the next edge: latch the address with bits [1:0] forced to 0, latch the length, clear both counters, and go to ISSUE.
REQ-019 In IDLE, rd_req=1 with rd_len=0 SHALL be ignored; the block stays in IDLE with rd_busy=0.
REQ-020 rd_busy SHALL be 1 in ISSUE and DRAIN, and 0 in IDLE.
REQ-021 rd_req SHALL be ignored in ISSUE and DRAIN, and no request is queued.
REQ-022 In ISSUE, mem_req SHALL be 1 when (issued - received) < MAX_OUT, using registered counts only; a same-cycle mem_rvalid does not free a slot until the next cycle.
REQ-023 mem_addr SHALL equal the latched base + 4*issued, wrapping modulo 2^DWIDTH.
REQ-024 Each cycle with mem_req and mem_gnt both high SHALL increment the issued count by 1.
REQ-025 mem_req and mem_addr SHALL hold stable while mem_gnt=0.
REQ-026 When the accepted request is number len, ISSUE SHALL go to DRAIN at that edge, and mem_req SHALL be 0 from the next cycle.
REQ-027 Each mem_rvalid in ISSUE or DRAIN SHALL produce, one cycle later: rd_valid=1 and rd_data=registered mem_rdata, and it increments the received count.
REQ-028 The response that makes received reach len SHALL, one cycle later, produce rd_valid=1 and rd_eof=1; the FSM goes to IDLE at the same edge.
REQ-029 rd_eof SHALL never be 1 while rd_valid=0.
REQ-030 mem_rvalid in IDLE SHALL be discarded: no rd_valid, no counter change.
REQ-031 A one-word burst SHALL go from ISSUE to DRAIN on its single grant; its word appears with rd_eof=1.
REQ-032 A len=4095 burst SHALL complete with no counter overflow; counters are 12 bits.
REQ-033 Since rd_valid has no backpressure, every response SHALL be forwarded exactly once in arrival order.
REQ-034 A new request SHALL be accepted in the first IDLE cycle after the rd_eof beat.

Reset
REQ-035 rst=1 at an edge SHALL force IDLE, clear the counters, and set rd_busy, rd_valid, rd_eof and mem_req to 0, and rd_data and mem_addr to 0.
REQ-036 rst during ISSUE or DRAIN SHALL abort the burst; later mem_rvalid from that burst is discarded per REQ-030.

Verification
REQ-037 rd_req, addr=0x1003, len=3, mem_gnt always 1, memory latency 1 -> mem_addr 0x1000, 0x1004, 0x1008; three rd_valid beats, rd_eof on the third only; rd_busy back to 0.
REQ-038 len=8, MAX_OUT=4, memory responds only after 10 cycles -> mem_req drops after 4 grants; issuing resumes the cycle after the first response is counted; 8 beats in order.
REQ-039 len=2 with mem_gnt toggling 0,1,0,1 -> mem_addr held during gnt=0; exactly 2 grants; rd_eof on beat 2.
REQ-040 rd_req with len=0, then a second rd_req during a busy burst -> both ignored; only the original burst's beats appear.
REQ-041 rst asserted after 2 of 5 responses, then stray mem_rvalid -> all outputs 0 after the edge; no rd_valid from the stray responses.
REQ-042 addr=0xFFFFFFFC, len=2 -> mem_addr 0xFFFFFFFC then 0x00000000.
